// File: rtl/ltu_tick_bin_cnt_pkg.sv
// Shared definitions for the LTU tick-driven binary counter: default width
// and the 2-bit state encoding used by the counter FSM.
package ltu_tick_bin_cnt_pkg;

    localparam int unsigned LTU_CNT_W = 8;

    typedef enum logic [1:0] {
        LTU_CNT_IDLE  = 2'd0,
        LTU_CNT_ARMED = 2'd1,
        LTU_CNT_RUN   = 2'd2,
        LTU_CNT_DONE  = 2'd3
    } ltu_cnt_state_e;

    // Next state ignoring enable and terminal events; load leaves DONE.
    function automatic ltu_cnt_state_e ltu_cnt_step(input ltu_cnt_state_e cur,
                                                     input logic stable,
                                                     input logic load);
        ltu_cnt_state_e nxt;
        nxt = cur;
        case (cur)
            LTU_CNT_IDLE:  nxt = LTU_CNT_ARMED;
            LTU_CNT_ARMED: nxt = stable ? LTU_CNT_RUN : LTU_CNT_ARMED;
            LTU_CNT_RUN:   nxt = stable ? LTU_CNT_RUN : LTU_CNT_ARMED;
            LTU_CNT_DONE:  nxt = load ? LTU_CNT_ARMED : LTU_CNT_DONE;
            default:       nxt = LTU_CNT_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ltu_cnt_core.sv
// Combinational next-count / terminal-count logic for the LTU binary counter.
// Up: wrap to 0 at or above limit. Down: wrap to limit at 0, clamp if above limit.
module ltu_cnt_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_count_c,
    output logic             term_c
);

    // Next value for a qualified tick and whether it is a terminal event.
    always_comb begin
        next_count_c = count;
        term_c       = 1'b0;
        if (up_dn) begin
            if (count >= limit) begin
                next_count_c = '0;
                term_c       = 1'b1;
            end else begin
                next_count_c = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                next_count_c = limit;
                term_c       = 1'b1;
            end else if (count > limit) begin
                next_count_c = limit;
            end else begin
                next_count_c = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ltu_tick_bin_cnt.sv
// Tick-driven up/down binary counter downstream of the LTU tick generator.
// Optional one-shot mode: define LTU_BIN_CNT_ONESHOT_EN to stop in DONE on
// the first terminal event instead of wrapping.
module ltu_tick_bin_cnt
    import ltu_tick_bin_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = LTU_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             stable,
    input  logic             tick,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped,
    output logic             running,
    output logic             done
);

    ltu_cnt_state_e   state;
    ltu_cnt_state_e   nxt_state_c;
    logic             qual_tick_c;
    logic [WIDTH-1:0] load_clamp_c;
    logic [WIDTH-1:0] next_count_c;
    logic             term_c;

    ltu_cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .count        (count),
        .limit        (limit),
        .up_dn        (up_dn),
        .next_count_c (next_count_c),
        .term_c       (term_c)
    );

    // Tick qualification, load clamp and base state transition.
    always_comb begin
        qual_tick_c  = (state == LTU_CNT_RUN) && stable && tick;
        load_clamp_c = (load_val > limit) ? limit : load_val;
        nxt_state_c  = ltu_cnt_step(state, stable, load);
    end

`ifdef LTU_BIN_CNT_ONESHOT_EN
    logic [WIDTH-1:0] term_val_c;
    logic             done_q;

    // Value held in DONE: limit when counting up, zero when counting down.
    always_comb begin
        term_val_c = up_dn ? limit : '0;
    end

    // FSM and output registers, one-shot variant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= LTU_CNT_IDLE;
            count   <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
            running <= 1'b0;
            done_q  <= 1'b0;
        end else if (!enable) begin
            state   <= LTU_CNT_IDLE;
            count   <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
            running <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tc      <= 1'b0;
            state   <= nxt_state_c;
            running <= (nxt_state_c == LTU_CNT_RUN);
            if (load) begin
                count   <= load_clamp_c;
                wrapped <= 1'b0;
                done_q  <= 1'b0;
            end else if (qual_tick_c) begin
                if (term_c) begin
                    count   <= term_val_c;
                    tc      <= 1'b1;
                    wrapped <= 1'b1;
                    done_q  <= 1'b1;
                    state   <= LTU_CNT_DONE;
                    running <= 1'b0;
                end else begin
                    count <= next_count_c;
                end
            end
        end
    end

    assign done = done_q;
`else
    // FSM and output registers, free-running wrap variant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= LTU_CNT_IDLE;
            count   <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
            running <= 1'b0;
        end else if (!enable) begin
            state   <= LTU_CNT_IDLE;
            count   <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
            running <= 1'b0;
        end else begin
            tc      <= 1'b0;
            state   <= nxt_state_c;
            running <= (nxt_state_c == LTU_CNT_RUN);
            if (load) begin
                count   <= load_clamp_c;
                wrapped <= 1'b0;
            end else if (qual_tick_c) begin
                count <= next_count_c;
                tc    <= term_c;
                if (term_c) begin
                    wrapped <= 1'b1;
                end
            end
        end
    end

    // DONE is unreachable without the one-shot option.
    assign done = 1'b0;
`endif

endmodule
